// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues reads to a 1-cycle synchronous IMEM, buffers
// returned words in a small FIFO and presents the head as the IF/ID register contents.
module fetch_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 10
) (
    input  logic                       clock,
    input  logic                       reset_n,
    output logic                       imem_req,
    output logic [IMEM_AW-1:0]         imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       ifid_stall,
    output logic                       ifid_valid,
    output logic [31:0]                ifid_ir,
    output logic [31:0]                ifid_pcplus4,
    output logic [31:0]                fetch_pc,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   ir_q  [DEPTH];
    logic [31:0]   ir_d  [DEPTH];
    logic [31:0]   pc4_q [DEPTH];
    logic [31:0]   pc4_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, inflight_d;
    logic          kill_q, kill_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;

    logic [CW:0]   occupancy;
    logic          push;
    logic          pop;

    // An in-flight read is counted as occupied so its returning word always has a slot.
    assign occupancy    = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign imem_req     = reset_n && !redirect && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr    = fetch_pc_q[IMEM_AW+1:2];
    assign fetch_pc     = fetch_pc_q;
    assign queue_count  = count_q;
    assign ifid_valid   = (count_q != '0);
    assign ifid_ir      = ifid_valid ? ir_q[rd_ptr_q]  : '0;
    assign ifid_pcplus4 = ifid_valid ? pc4_q[rd_ptr_q] : '0;

    assign push = inflight_q && !kill_q && !redirect;
    assign pop  = ifid_valid && !ifid_stall && !redirect;

    always_comb begin
        ir_d       = ir_q;
        pc4_d      = pc4_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = imem_req;
        kill_d     = redirect;
        req_addr_d = imem_req ? fetch_pc_q : req_addr_q;
        fetch_pc_d = imem_req ? fetch_pc_q + 32'd4 : fetch_pc_q;

        if (redirect) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else begin
            if (push) begin
                ir_d[wr_ptr_q]  = imem_rdata;
                pc4_d[wr_ptr_q] = req_addr_q + 32'd4;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(negedge clock) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Queue storage needs no reset: entries are only visible through count_q.
    always_ff @(negedge clock) begin
        ir_q  <= ir_d;
        pc4_q <= pc4_d;
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed self-checking bench for fetch_prefetch_unit with a 1-cycle synchronous IMEM model.
module tb_fetch_prefetch_unit;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_stall;
    logic        ifid_valid;
    logic [31:0] ifid_ir;
    logic [31:0] ifid_pcplus4;
    logic [31:0] fetch_pc;
    logic [2:0]  queue_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [1024];

    fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .ifid_stall(ifid_stall),
        .ifid_valid(ifid_valid), .ifid_ir(ifid_ir), .ifid_pcplus4(ifid_pcplus4),
        .fetch_pc(fetch_pc), .queue_count(queue_count)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    // IMEM: word k holds 0xA000_0000 + k, read data valid the cycle after the request.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
        imem_rdata = '0;
    end
    always @(negedge clock) if (imem_req) imem_rdata <= mem[imem_addr];

    // Move to mid-cycle (between state-updating falling edges).
    task automatic mid();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ifid_stall = 1'b0;
        mid();
        mid();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%0b required=0", ifid_valid); end
        checks++; if (ifid_ir !== 32'h0) begin errors++; $display("FAIL reset_ir actual=%h required=0", ifid_ir); end
        checks++; if (ifid_pcplus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 actual=%h required=0", ifid_pcplus4); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req actual=%0b required=0", imem_req); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL reset_count actual=%0d required=0", queue_count); end
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL reset_fetch_pc actual=%h required=0", fetch_pc); end
    endtask

    task automatic test_basic();
        do_reset();
        reset_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_req actual=%0b required=1", imem_req); end
        checks++; if (imem_addr !== 10'd0) begin errors++; $display("FAIL basic_addr actual=%0d required=0", imem_addr); end
        mid();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid actual=%0b required=0", ifid_valid); end
        for (int k = 0; k < 4; k++) begin
            mid();
            checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] actual=%0b required=1", k, ifid_valid); end
            checks++; if (ifid_ir !== 32'hA000_0000 + k) begin errors++; $display("FAIL basic_ir[%0d] actual=%h required=%h", k, ifid_ir, 32'hA000_0000 + k); end
            checks++; if (ifid_pcplus4 !== 32'd4 * (k + 1)) begin errors++; $display("FAIL basic_pc4[%0d] actual=%h required=%h", k, ifid_pcplus4, 32'd4 * (k + 1)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        ifid_stall = 1'b1;
        reset_n = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) mid();
            checks++; if (imem_req !== (c < 4)) begin errors++; $display("FAIL stall_req[c%0d] actual=%0b required=%0b", c, imem_req, c < 4); end
            if (c >= 2) begin
                checks++; if (ifid_ir !== 32'hA000_0000) begin errors++; $display("FAIL stall_hold_ir[c%0d] actual=%h required=a0000000", c, ifid_ir); end
            end
            if (c >= 5) begin
                checks++; if (queue_count !== 3'd4) begin errors++; $display("FAIL stall_count[c%0d] actual=%0d required=4", c, queue_count); end
            end
        end
        mid();
        ifid_stall = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) mid();
            checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_rel_valid[%0d] actual=%0b required=1", k, ifid_valid); end
            checks++; if (ifid_ir !== 32'hA000_0000 + k) begin errors++; $display("FAIL stall_rel_ir[%0d] actual=%h required=%h", k, ifid_ir, 32'hA000_0000 + k); end
            checks++; if (ifid_pcplus4 !== 32'd4 * (k + 1)) begin errors++; $display("FAIL stall_rel_pc4[%0d] actual=%h required=%h", k, ifid_pcplus4, 32'd4 * (k + 1)); end
        end
    endtask

    // Redirect in a cycle that also pops the head and has a response in flight.
    task automatic test_redirect();
        do_reset();
        reset_n = 1'b1;
        mid();
        mid();
        mid();
        redirect = 1'b1; redirect_pc = 32'h0000_003C;
        #1;
        checks++; if (ifid_ir !== 32'hA000_0001) begin errors++; $display("FAIL redir_pre_ir actual=%h required=a0000001", ifid_ir); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req actual=%0b required=0", imem_req); end
        mid();
        redirect = 1'b0;
        #1;
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL redir_count actual=%0d required=0", queue_count); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_valid0 actual=%0b required=0", ifid_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL redir_req1 actual=%0b required=1", imem_req); end
        checks++; if (imem_addr !== 10'd15) begin errors++; $display("FAIL redir_addr actual=%0d required=15", imem_addr); end
        mid();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_valid1 actual=%0b required=0", ifid_valid); end
        for (int k = 0; k < 3; k++) begin
            mid();
            checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL redir_tgt_valid[%0d] actual=%0b required=1", k, ifid_valid); end
            checks++; if (ifid_ir !== 32'hA000_000F + k) begin errors++; $display("FAIL redir_tgt_ir[%0d] actual=%h required=%h", k, ifid_ir, 32'hA000_000F + k); end
            checks++; if (ifid_pcplus4 !== 32'h40 + 4 * k) begin errors++; $display("FAIL redir_tgt_pc4[%0d] actual=%h required=%h", k, ifid_pcplus4, 32'h40 + 4 * k); end
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        reset_n = 1'b1;
        mid();
        mid();
        redirect = 1'b1; redirect_pc = 32'h0000_003E;
        mid();
        redirect = 1'b0;
        #1;
        checks++; if (fetch_pc !== 32'h3C) begin errors++; $display("FAIL misal_fetch_pc actual=%h required=3c", fetch_pc); end
        checks++; if (imem_addr !== 10'd15) begin errors++; $display("FAIL misal_addr actual=%0d required=15", imem_addr); end
        mid();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL misal_valid0 actual=%0b required=0", ifid_valid); end
        mid();
        checks++; if (ifid_ir !== 32'hA000_000F) begin errors++; $display("FAIL misal_ir actual=%h required=a000000f", ifid_ir); end
        checks++; if (ifid_pcplus4 !== 32'h40) begin errors++; $display("FAIL misal_pc4 actual=%h required=40", ifid_pcplus4); end
    endtask

    task automatic test_wrap();
        do_reset();
        reset_n = 1'b1;
        mid();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        mid();
        redirect = 1'b0;
        #1;
        checks++; if (fetch_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fetch_pc actual=%h required=fffffffc", fetch_pc); end
        checks++; if (imem_addr !== 10'h3FF) begin errors++; $display("FAIL wrap_addr actual=%h required=3ff", imem_addr); end
        mid();
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL wrap_fetch_pc_next actual=%h required=0", fetch_pc); end
        mid();
        checks++; if (ifid_ir !== 32'hA000_03FF) begin errors++; $display("FAIL wrap_ir actual=%h required=a00003ff", ifid_ir); end
        checks++; if (ifid_pcplus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 actual=%h required=0", ifid_pcplus4); end
        mid();
        checks++; if (ifid_ir !== 32'hA000_0000) begin errors++; $display("FAIL wrap_next_ir actual=%h required=a0000000", ifid_ir); end
        checks++; if (ifid_pcplus4 !== 32'h4) begin errors++; $display("FAIL wrap_next_pc4 actual=%h required=4", ifid_pcplus4); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ifid_stall = 1'b1;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) mid();
        checks++; if (queue_count !== 3'd3) begin errors++; $display("FAIL rstmid_pre_count actual=%0d required=3", queue_count); end
        reset_n = 1'b0;
        mid();
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL rstmid_count actual=%0d required=0", queue_count); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid actual=%0b required=0", ifid_valid); end
        checks++; if (ifid_ir !== 32'h0) begin errors++; $display("FAIL rstmid_ir actual=%h required=0", ifid_ir); end
        checks++; if (ifid_pcplus4 !== 32'h0) begin errors++; $display("FAIL rstmid_pc4 actual=%h required=0", ifid_pcplus4); end
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL rstmid_fetch_pc actual=%h required=0", fetch_pc); end
        ifid_stall = 1'b0;
        reset_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin errors++; $display("FAIL rstmid_restart_req actual=%0b/%0d required=1/0", imem_req, imem_addr); end
        mid();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rstmid_restart_early actual=%0b required=0", ifid_valid); end
        mid();
        checks++; if (ifid_ir !== 32'hA000_0000) begin errors++; $display("FAIL rstmid_restart_ir actual=%h required=a0000000", ifid_ir); end
        checks++; if (ifid_pcplus4 !== 32'h4) begin errors++; $display("FAIL rstmid_restart_pc4 actual=%h required=4", ifid_pcplus4); end
    endtask

    initial begin
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ifid_stall = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
